// File: rtl/stream_demux_1_4_if.sv
// Handshake bundle for the 1-to-4 stream demux:
// one upstream valid/ready port, four registered downstream channels.
interface stream_demux_1_4_if #(
  parameter int W = 4
);
  logic         up_valid;
  logic         up_ready;
  logic [1:0]   up_sel;
  logic [W-1:0] up_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0;
  logic [W-1:0] out_data1;
  logic [W-1:0] out_data2;
  logic [W-1:0] out_data3;

  modport master (
    output up_valid, up_sel, up_data, out_ready,
    input  up_ready, out_valid,
    input  out_data0, out_data1, out_data2, out_data3
  );

  modport slave (
    input  up_valid, up_sel, up_data, out_ready,
    output up_ready, out_valid,
    output out_data0, out_data1, out_data2, out_data3
  );
endinterface

// File: rtl/stream_demux_1_4.sv
// 1:4 stream demux with a one-entry slice per channel.
// Define STREAM_DEMUX_CNT_EN to add saturating per-channel accept counters.
module stream_demux_1_4 #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  stream_demux_1_4_if.slave   bus
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [7:0]          cnt0,
  output logic [7:0]          cnt1,
  output logic [7:0]          cnt2,
  output logic [7:0]          cnt3
`endif
);

  logic [3:0]   vld_q, vld_d;
  logic [W-1:0] dat_q [4];
  logic [W-1:0] dat_d [4];
  logic [3:0]   can_take;
  logic [3:0]   load;
  logic         up_ready;

  // A full slot still accepts when its consumer drains it this cycle.
  assign can_take = ~vld_q | bus.out_ready;
  assign up_ready = ~rst & can_take[bus.up_sel];

  always_comb begin
    load = 4'b0000;
    if (bus.up_valid && up_ready)
      load = 4'b0001 << bus.up_sel;
  end

  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < 4; i++) begin
      dat_d[i] = dat_q[i];
      if (load[i]) begin
        vld_d[i] = 1'b1;
        dat_d[i] = bus.up_data;
      end else if (vld_q[i] && bus.out_ready[i]) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 4'b0000;
      for (int i = 0; i < 4; i++)
        dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < 4; i++)
        dat_q[i] <= dat_d[i];
    end
  end

  assign bus.up_ready  = up_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_data0 = dat_q[0];
  assign bus.out_data1 = dat_q[1];
  assign bus.out_data2 = dat_q[2];
  assign bus.out_data3 = dat_q[3];

`ifdef STREAM_DEMUX_CNT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (load[i] && cnt_q[i] != 8'hFF)
        cnt_d[i] = cnt_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule
